// File: rtl/sdram_device_responder.sv
// Device-side model of a 16-bit SDR SDRAM: decodes the controller's command pins,
// tracks open rows per bank, applies CAS latency and backs accesses with on-chip memory.
module sdram_device_responder #(
  parameter int ROW_BITS      = 13,
  parameter int COL_BITS      = 10,
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ROW_BITS-1:0] sdram_addr,
  input  logic [1:0]          sdram_ba,
  input  logic                sdram_cs_n,
  input  logic                sdram_ras_n,
  input  logic                sdram_cas_n,
  input  logic                sdram_we_n,
  input  logic                sdram_cke,
  input  logic [1:0]          sdram_dqm,
  input  logic [15:0]         sdram_dq_in,
  output logic [15:0]         sdram_dq_out,
  output logic                sdram_dq_oe,
  output logic                init_done,
  output logic                err_pulse,
  output logic [2:0]          err_code,
  output logic [15:0]         refresh_count
);

  // state       | meaning
  // S_WAIT_PRE  | power-up, waiting for PRECHARGE-all
  // S_WAIT_REF1 | waiting for first AUTO REFRESH
  // S_WAIT_REF2 | waiting for second AUTO REFRESH
  // S_WAIT_MRS  | waiting for a legal LOAD MODE
  // S_READY     | initialized, normal command handling
  typedef enum logic [2:0] {
    S_WAIT_PRE, S_WAIT_REF1, S_WAIT_REF2, S_WAIT_MRS, S_READY
  } state_t;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_BST = 3'b110;
  localparam int IDX_BITS = 2 + ROW_BITS + COL_BITS;

  state_t state, state_nxt;

  logic [3:0]               bank_open;
  logic [ROW_BITS-1:0]      bank_row [4];
  logic [2:0]               cas_lat;
  logic [15:0]              mem [2**MEM_ADDR_BITS];
  logic [IDX_BITS-1:0]      full_idx;
  logic [MEM_ADDR_BITS-1:0] mem_idx;
  logic [15:0]              rd_data;

  logic        pipe_v0, pipe_v1;
  logic [15:0] pipe_d0, pipe_d1;

  logic [2:0] cmd;
  logic       cmd_live, mode_ok, any_open, sel_open;
  logic       do_act, do_rd, do_wr, do_pre, do_ref, do_mrs;
  logic [2:0] err_val;

  assign cmd      = {sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign cmd_live = !sdram_cs_n && sdram_cke && (cmd != CMD_NOP) && (cmd != CMD_BST);
  assign mode_ok  = (sdram_addr[2:0] == 3'b000) &&
                    ((sdram_addr[6:4] == 3'b010) || (sdram_addr[6:4] == 3'b011));
  assign any_open = |bank_open;
  assign sel_open = bank_open[sdram_ba];
  assign full_idx = {sdram_ba, bank_row[sdram_ba], sdram_addr[COL_BITS-1:0]};
  assign mem_idx  = MEM_ADDR_BITS'(full_idx);
  assign rd_data  = mem[mem_idx];
  assign init_done = (state == S_READY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_WAIT_PRE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_act    = 1'b0;
    do_rd     = 1'b0;
    do_wr     = 1'b0;
    do_pre    = 1'b0;
    do_ref    = 1'b0;
    do_mrs    = 1'b0;
    err_val   = 3'd0;
    if (cmd_live) begin
      case (state)
        S_WAIT_PRE: begin
          if (cmd == CMD_PRE && sdram_addr[10]) state_nxt = S_WAIT_REF1;
          else                                  err_val   = 3'd4;
        end
        S_WAIT_REF1, S_WAIT_REF2: begin
          if (cmd == CMD_REF) begin
            do_ref    = 1'b1;
            state_nxt = (state == S_WAIT_REF1) ? S_WAIT_REF2 : S_WAIT_MRS;
          end else begin
            err_val = 3'd4;
          end
        end
        S_WAIT_MRS: begin
          if (cmd != CMD_LMR) err_val = 3'd4;
          else if (!mode_ok)  err_val = 3'd6;
          else begin
            do_mrs    = 1'b1;
            state_nxt = S_READY;
          end
        end
        S_READY: begin
          case (cmd)
            CMD_ACT: if (sel_open) err_val = 3'd3; else do_act = 1'b1;
            CMD_RD:  if (!sel_open) err_val = 3'd1; else do_rd = 1'b1;
            CMD_WR: begin
              if (!sel_open) err_val = 3'd2;
              else begin
                // contention is flagged but the write still lands
                do_wr = 1'b1;
                if (sdram_dq_oe) err_val = 3'd7;
              end
            end
            CMD_PRE: do_pre = 1'b1;
            CMD_REF: if (any_open) err_val = 3'd5; else do_ref = 1'b1;
            CMD_LMR: begin
              if (any_open)     err_val = 3'd5;
              else if (!mode_ok) err_val = 3'd6;
              else               do_mrs = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_nxt = S_WAIT_PRE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_open     <= 4'b0000;
      cas_lat       <= 3'd3;
      refresh_count <= 16'h0000;
      err_pulse     <= 1'b0;
      err_code      <= 3'd0;
    end else begin
      if (do_act) bank_open[sdram_ba] <= 1'b1;
      if (do_pre) begin
        if (sdram_addr[10]) bank_open <= 4'b0000;
        else                bank_open[sdram_ba] <= 1'b0;
      end
      if (do_mrs) cas_lat <= sdram_addr[6:4];
      if (do_ref && refresh_count != 16'hFFFF) refresh_count <= refresh_count + 16'd1;
      err_pulse <= (err_val != 3'd0);
      if (err_val != 3'd0) err_code <= err_val;
    end
  end

  always_ff @(posedge clk) begin
    if (do_act) bank_row[sdram_ba] <= sdram_addr;
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      if (!sdram_dqm[0]) mem[mem_idx][7:0]  <= sdram_dq_in[7:0];
      if (!sdram_dqm[1]) mem[mem_idx][15:8] <= sdram_dq_in[15:8];
    end
  end

  // CL3 reads enter one stage earlier than CL2 reads; in-flight reads keep their slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v1      <= 1'b0;
      pipe_d1      <= 16'h0000;
      pipe_v0      <= 1'b0;
      pipe_d0      <= 16'h0000;
      sdram_dq_oe  <= 1'b0;
      sdram_dq_out <= 16'h0000;
    end else begin
      pipe_v1 <= do_rd && (cas_lat != 3'd2);
      pipe_d1 <= rd_data;
      if (do_rd && cas_lat == 3'd2) begin
        pipe_v0 <= 1'b1;
        pipe_d0 <= rd_data;
      end else begin
        pipe_v0 <= pipe_v1;
        pipe_d0 <= pipe_d1;
      end
      sdram_dq_oe  <= pipe_v0;
      sdram_dq_out <= pipe_v0 ? pipe_d0 : 16'h0000;
    end
  end

endmodule

// File: tb/tb_sdram_device_responder.sv
// Bench for sdram_device_responder: directed protocol scenarios followed by random
// command traffic, all compared against a behavioural SDRAM model.
module tb_sdram_device_responder;
  localparam int ROW_BITS = 13, COL_BITS = 10, MEM_ADDR_BITS = 12;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000, C_BST = 3'b110;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dq_in, sdram_dq_out;
  logic        sdram_dq_oe, init_done, err_pulse;
  logic [2:0]  err_code;
  logic [15:0] refresh_count;

  always #5 clk = ~clk;

  sdram_device_responder #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .MEM_ADDR_BITS(MEM_ADDR_BITS)) dut (
    .clk(clk), .reset_n(reset_n), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_cke(sdram_cke), .sdram_dqm(sdram_dqm),
    .sdram_dq_in(sdram_dq_in), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .init_done(init_done), .err_pulse(err_pulse), .err_code(err_code),
    .refresh_count(refresh_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model state
  int          m_stage;   // number of init steps completed, 4 = ready
  bit          m_open [4];
  int          m_row  [4];
  int          m_cl, m_ref, m_code, cyc;
  bit          m_pulse, m_oe;
  logic [15:0] m_dq, m_mask;
  logic [15:0] m_mem   [2**MEM_ADDR_BITS];
  bit   [1:0]  m_known [2**MEM_ADDR_BITS];
  bit          s_v [8];
  logic [15:0] s_d [8];
  logic [15:0] s_m [8];

  function automatic int mem_index(input int ba, input int row, input int col);
    longint full;
    full = (longint'(ba) << (ROW_BITS + COL_BITS)) + (longint'(row) << COL_BITS) + longint'(col);
    return int'(full % (longint'(1) << MEM_ADDR_BITS));
  endfunction

  function automatic bit mode_legal(input logic [12:0] a);
    return (a[2:0] == 3'b000) && (a[6:4] == 3'd2 || a[6:4] == 3'd3);
  endfunction

  function automatic bit reads_pending();
    bit p = 1'b0;
    for (int i = 0; i < 8; i++) p |= s_v[i];
    return p;
  endfunction

  task automatic model_reset();
    m_stage = 0; m_cl = 3; m_ref = 0; m_code = 0; m_pulse = 0; m_oe = 0;
    m_dq = 0; m_mask = 0; cyc = 0;
    for (int i = 0; i < 4; i++) begin m_open[i] = 0; m_row[i] = 0; end
    for (int i = 0; i < 8; i++) s_v[i] = 0;
  endtask

  task automatic model_edge(input bit cs_n, input bit cke, input logic [2:0] c, input int ba,
                            input logic [12:0] a, input logic [1:0] dqm, input logic [15:0] d);
    int e, idx, slot, col;
    bit any_open;
    e = 0;
    col = int'(a) % (1 << COL_BITS);
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    if (!cs_n && cke && c != C_NOP && c != C_BST) begin
      if (m_stage < 4) begin
        if (m_stage == 0 && c == C_PRE && a[10]) m_stage = 1;
        else if ((m_stage == 1 || m_stage == 2) && c == C_REF) begin m_stage++; m_ref++; end
        else if (m_stage == 3 && c == C_LMR) begin
          if (mode_legal(a)) begin m_cl = int'(a[6:4]); m_stage = 4; end
          else e = 6;
        end else e = 4;
      end else begin
        case (c)
          C_ACT: if (m_open[ba]) e = 3; else begin m_open[ba] = 1; m_row[ba] = int'(a); end
          C_RD: begin
            if (!m_open[ba]) e = 1;
            else begin
              idx  = mem_index(ba, m_row[ba], col);
              slot = (cyc + m_cl - 1) % 8;
              s_v[slot] = 1;
              s_d[slot] = m_mem[idx];
              s_m[slot] = {{8{m_known[idx][1]}}, {8{m_known[idx][0]}}};
            end
          end
          C_WR: begin
            if (!m_open[ba]) e = 2;
            else begin
              if (m_oe) e = 7;
              idx = mem_index(ba, m_row[ba], col);
              if (!dqm[0]) begin m_mem[idx][7:0]  = d[7:0];  m_known[idx][0] = 1; end
              if (!dqm[1]) begin m_mem[idx][15:8] = d[15:8]; m_known[idx][1] = 1; end
            end
          end
          C_PRE: begin
            if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
            else m_open[ba] = 0;
          end
          C_REF: if (any_open) e = 5; else if (m_ref < 65535) m_ref++;
          C_LMR: if (any_open) e = 5; else if (!mode_legal(a)) e = 6; else m_cl = int'(a[6:4]);
          default: ;
        endcase
      end
    end
    m_pulse = (e != 0);
    if (e != 0) m_code = e;
    slot = cyc % 8;
    m_oe = s_v[slot]; m_dq = s_d[slot]; m_mask = s_m[slot];
    s_v[slot] = 0;
    cyc++;
  endtask

  task automatic compare_all();
    check("dq_oe", sdram_dq_oe, m_oe);
    if (m_oe) check("dq_out", sdram_dq_out & m_mask, m_dq & m_mask);
    check("err_pulse", err_pulse, m_pulse);
    check("err_code", err_code, m_code);
    check("init_done", init_done, m_stage == 4);
    check("refresh_count", refresh_count, m_ref);
  endtask

  task automatic step(input logic [2:0] c, input int ba = 0, input logic [12:0] a = 13'h0,
                      input logic [1:0] dqm = 2'b00, input logic [15:0] d = 16'h0,
                      input bit cs_n = 1'b0, input bit cke = 1'b1);
    sdram_cs_n = cs_n; sdram_cke = cke;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba = 2'(ba); sdram_addr = a; sdram_dqm = dqm; sdram_dq_in = d;
    @(posedge clk);
    model_edge(cs_n, cke, c, ba, a, dqm, d);
    #1;
    compare_all();
  endtask

  task automatic init_seq();
    step(C_PRE, 0, 13'h400);
    step(C_REF);
    step(C_REF);
    step(C_LMR, 0, 13'h030);
  endtask

  function automatic logic [12:0] pick_row(input int k);
    case (k)
      0: return 13'h005;
      1: return 13'h006;
      2: return 13'h1A7;
      default: return 13'h002;
    endcase
  endfunction

  function automatic logic [12:0] pick_mode(input int k);
    case (k)
      0: return 13'h020;
      1: return 13'h030;
      2: return 13'h001;
      3: return 13'h034;
      default: return 13'h050;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, rba;
    logic [12:0] ra;
    logic [2:0]  rc;
    bit rcs, rcke;

    sdram_cs_n = 1; sdram_cke = 1; {sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
    sdram_ba = 0; sdram_addr = 0; sdram_dqm = 0; sdram_dq_in = 0;
    reset_n = 1'b0;
    model_reset();
    #12;
    check("rst_dq_oe", sdram_dq_oe, 0);
    check("rst_dq_out", sdram_dq_out, 0);
    check("rst_init_done", init_done, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_code", err_code, 0);
    check("rst_refresh", refresh_count, 0);
    #11 reset_n = 1'b1;

    // init with a premature ACTIVE
    step(C_NOP);
    step(C_PRE, 0, 13'h400);
    step(C_REF);
    step(C_REF);
    step(C_ACT, 0, 13'h005);
    check("early_act_code", err_code, 4);
    step(C_LMR, 0, 13'h030);
    check("init_done_set", init_done, 1);
    check("init_refresh", refresh_count, 2);
    check("init_no_err", err_pulse, 0);

    // CL3 write then read
    step(C_ACT, 1, 13'h005);
    step(C_WR, 1, 13'h010, 2'b00, 16'hA5C3);
    step(C_RD, 1, 13'h010);
    check("cl3_oe_t", sdram_dq_oe, 0);
    step(C_NOP);
    check("cl3_oe_t1", sdram_dq_oe, 0);
    step(C_NOP);
    check("cl3_oe_t3", sdram_dq_oe, 1);
    check("cl3_data", sdram_dq_out, 16'hA5C3);
    step(C_NOP);
    check("cl3_oe_once", sdram_dq_oe, 0);

    // byte mask and back-to-back reads
    step(C_WR, 1, 13'h011, 2'b00, 16'h1234);
    step(C_WR, 1, 13'h011, 2'b01, 16'hFFFF);
    step(C_RD, 1, 13'h011);
    step(C_RD, 1, 13'h011);
    step(C_NOP);
    check("b2b_oe0", sdram_dq_oe, 1);
    check("b2b_data0", sdram_dq_out, 16'hFF34);
    step(C_NOP);
    check("b2b_oe1", sdram_dq_oe, 1);
    check("b2b_data1", sdram_dq_out, 16'hFF34);
    step(C_NOP);
    check("b2b_oe_end", sdram_dq_oe, 0);

    // violations
    step(C_RD, 1, 13'h010);
    step(C_NOP);
    step(C_NOP);
    step(C_WR, 1, 13'h012, 2'b00, 16'h0F0F);
    check("contention_code", err_code, 7);
    check("contention_pulse", err_pulse, 1);
    step(C_ACT, 1, 13'h005);
    check("act_twice_code", err_code, 3);
    step(C_REF);
    check("ref_open_code", err_code, 5);
    check("ref_open_count", refresh_count, 2);
    step(C_RD, 2, 13'h000);
    check("rd_closed_code", err_code, 1);
    repeat (3) begin
      step(C_NOP);
      check("rd_closed_oe", sdram_dq_oe, 0);
    end

    // CL2
    step(C_PRE, 0, 13'h400);
    step(C_LMR, 0, 13'h020);
    step(C_ACT, 0, 13'h006);
    step(C_WR, 0, 13'h003, 2'b00, 16'hBEEF);
    step(C_RD, 0, 13'h003);
    check("cl2_oe_t", sdram_dq_oe, 0);
    step(C_NOP);
    check("cl2_oe_t2", sdram_dq_oe, 1);
    check("cl2_data", sdram_dq_out, 16'hBEEF);
    step(C_NOP);
    check("cl2_oe_once", sdram_dq_oe, 0);
    step(C_PRE, 0, 13'h400);
    step(C_LMR, 0, 13'h001);
    check("bad_mode_code", err_code, 6);
    step(C_ACT, 0, 13'h006);
    step(C_RD, 0, 13'h003);
    step(C_NOP);
    check("cl2_kept_oe", sdram_dq_oe, 1);
    check("cl2_kept_data", sdram_dq_out, 16'hBEEF);
    step(C_NOP);

    // reset while a CL3 read is in flight
    step(C_PRE, 0, 13'h400);
    step(C_LMR, 0, 13'h030);
    step(C_ACT, 1, 13'h005);
    step(C_RD, 1, 13'h010);
    step(C_NOP);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_oe", sdram_dq_oe, 0);
    check("rst_mid_init", init_done, 0);
    model_reset();
    @(posedge clk);
    #1 check("rst_mid_oe_t2", sdram_dq_oe, 0);
    #2 reset_n = 1'b1;
    init_seq();
    step(C_ACT, 1, 13'h005);
    step(C_RD, 1, 13'h010);
    step(C_NOP);
    step(C_NOP);
    check("reinit_oe", sdram_dq_oe, 1);
    check("reinit_data", sdram_dq_out, 16'hA5C3);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      rba = $urandom_range(0, 3);
      ra = ($urandom_range(0, 3) == 0) ? 13'h010 : 13'($urandom_range(0, 7));
      rc = C_NOP; rcs = 1'b0; rcke = 1'b1;
      if (r < 18) begin rc = C_ACT; ra = pick_row($urandom_range(0, 3)); end
      else if (r < 40) rc = C_RD;
      else if (r < 60) rc = C_WR;
      else if (r < 72) begin rc = C_PRE; ra = ($urandom_range(0, 1) != 0) ? 13'h400 : 13'h000; end
      else if (r < 78) rc = C_REF;
      else if (r < 84) begin
        if (!reads_pending()) begin rc = C_LMR; ra = pick_mode($urandom_range(0, 4)); end
      end
      else if (r < 90) begin rc = 3'($urandom_range(0, 7)); rcs = 1'b1; end
      else if (r < 94) begin rc = 3'($urandom_range(0, 7)); rcke = 1'b0; end
      else if (r < 97) rc = C_BST;
      step(rc, rba, ra, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
           16'($urandom), rcs, rcke);
    end
    repeat (4) step(C_NOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
